// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns a debounced button level into press/release/short/long/repeat pulses and a press counter.
module button_event_ctrl #(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 D_in,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic                 short_press,
  output logic                 long_press,
  output logic                 repeat_pulse,
  output logic [CNT_WIDTH-1:0] press_count,
  output logic                 held
);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic [CNT_WIDTH-1:0] count_n;
  logic press_n, release_n, short_n, long_n, repeat_n;
  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    rep_n     = rep_cnt;
    count_n   = press_count;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: if (D_in) begin
        state_n = PRESSED;
        hold_n  = HW'(1);
        press_n = 1'b1;
        count_n = press_count + CNT_WIDTH'(1);
      end
      PRESSED: if (!D_in) begin
        state_n   = IDLE;
        release_n = 1'b1;
        short_n   = 1'b1;
      end else if (hold_cnt == HOLD_MAX) begin
        state_n = LONG;
        long_n  = 1'b1;
        rep_n   = '0;
      end else hold_n = hold_cnt + HW'(1);
      LONG: if (!D_in) begin
        state_n   = IDLE;
        release_n = 1'b1;
      end else begin
        repeat_n = rep_cnt == REP_MAX;
        rep_n    = repeat_n ? '0 : rep_cnt + RW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_count   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_n;
      rep_cnt       <= rep_n;
      press_count   <= count_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_press   <= short_n;
      long_press    <= long_n;
      repeat_pulse  <= repeat_n;
      held          <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed vector table plus hand sequences for long hold and counter wrap.
module tb_button_event_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic D_in = 1'b0;
  logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
  logic [7:0] press_count;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic       r;
    logic       d;
    logic [5:0] f;
    logic [7:0] c;
  } vec_t;
  vec_t v[$];
  button_event_ctrl #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .D_in(D_in), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .short_press(short_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .press_count(press_count), .held(held)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] outs();
    return {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held, press_count};
  endfunction
  task automatic add(input logic r, input logic d, input logic [5:0] f, input logic [7:0] c);
    vec_t x;
    x.r = r; x.d = d; x.f = f; x.c = c;
    v.push_back(x);
  endtask
  task automatic step(input logic r, input logic d);
    reset = r;
    D_in  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  initial begin
    // reset, then the first edge with D_in high is a new press
    add(1, 0, 6'b000000, 0); add(1, 1, 6'b000000, 0);
    add(0, 1, 6'b100001, 1); add(0, 1, 6'b000001, 1); add(0, 1, 6'b000001, 1);
    add(0, 0, 6'b011000, 1); add(0, 0, 6'b000000, 1);
    // single-cycle glitch
    add(0, 1, 6'b100001, 2); add(0, 0, 6'b011000, 2); add(0, 0, 6'b000000, 2);
    // held 7 samples: still short
    add(0, 1, 6'b100001, 3);
    for (int i = 0; i < 6; i++) add(0, 1, 6'b000001, 3);
    add(0, 0, 6'b011000, 3); add(0, 0, 6'b000000, 3);
    // held 8 samples: long, then plain release
    add(0, 1, 6'b100001, 4);
    for (int i = 0; i < 6; i++) add(0, 1, 6'b000001, 4);
    add(0, 1, 6'b000101, 4); add(0, 0, 6'b010000, 4); add(0, 0, 6'b000000, 4);
    // reset for 2 cycles at sample 10 of a hold, D_in stays high
    add(0, 1, 6'b100001, 5);
    for (int i = 0; i < 6; i++) add(0, 1, 6'b000001, 5);
    add(0, 1, 6'b000101, 5); add(0, 1, 6'b000001, 5);
    add(1, 1, 6'b000000, 0); add(1, 1, 6'b000000, 0);
    add(0, 1, 6'b100001, 1);
    for (int i = 0; i < 6; i++) add(0, 1, 6'b000001, 1);
    add(0, 1, 6'b000101, 1); add(0, 0, 6'b010000, 1); add(0, 0, 6'b000000, 1);
    foreach (v[i]) begin
      step(v[i].r, v[i].d);
      check($sformatf("vec%0d", i), 32'(outs()), 32'({v[i].f, v[i].c}));
    end
    // 20-sample hold: long at 8, repeats at 12/16/20
    for (int i = 1; i <= 20; i++) begin
      step(0, 1);
      check($sformatf("hold20_s%0d", i), 32'(outs()),
            32'({i == 1, 2'b00, i == 8, i >= 12 && i % 4 == 0, 1'b1, 8'd2}));
    end
    step(0, 0);
    check("hold20_release", 32'(outs()), 32'({6'b010000, 8'd2}));
    // 256 short presses from a fresh reset: counter wraps back to 0
    begin
      int np = 0;
      int ns = 0;
      int both = 0;
      step(1, 0);
      check("wrap_reset", 32'(outs()), 32'({6'b000000, 8'd0}));
      for (int i = 0; i < 256; i++) begin
        step(0, 1); np += press_pulse; both += press_pulse & release_pulse;
        if (i == 254) check("wrap_cnt255", 32'(press_count), 32'd255);
        step(0, 1); np += press_pulse;
        step(0, 0); ns += short_press; both += press_pulse & release_pulse;
        step(0, 0); ns += short_press;
      end
      check("wrap_press_pulses", 32'(np), 32'd256);
      check("wrap_short_pulses", 32'(ns), 32'd256);
      check("wrap_overlap", 32'(both), 32'd0);
      check("wrap_count", 32'(press_count), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
